// File: rtl/mean_filter.sv
// ---------------------------------------------------------------------------
// mean_filter
//
// Block-average (decimating) mean filter for an unsigned sample stream.
// The filter sums N accepted samples into a non-overlapping window. At the
// end of each window it emits floor(sum/N), or the round-half-up mean when
// ROUND=1, together with a one-cycle done strobe. It then starts the next
// window straight away.
//
// Parameters
//   DATA_W  width of input samples and of the mean output (unsigned)
//   N       samples per window, integer >= 2
//   ROUND   0 = truncate (floor), 1 = round half up: (sum + N/2) / N
//
// Ports
//   clk     in   1       single clock, all logic on the rising edge
//   rst     in   1       synchronous, active-high reset
//   en_i    in   1       sample valid; data_i is taken on every edge with en_i=1
//   data_i  in   DATA_W  unsigned input sample
//   data_o  out  DATA_W  mean of the last completed window, held between windows
//   done_o  out  1       one-cycle pulse; data_o changes on the same edge
//
// Handshake: there is no ready signal and no back-pressure. The block accepts
// every cycle with en_i=1, and a cycle with en_i=0 is a gap that leaves the
// window untouched. done_o is a valid-only strobe and carries no
// acknowledge: data_o is the result on the cycle done_o is high, and it stays
// stable until the next strobe.
//
// Pipeline
//   accumulate : acc/cnt collect samples. The edge that accepts the Nth
//                sample loads the stage-1 total and sets stage-1 valid.
//   stage 2    : on the following edge the total is divided by the constant
//                N, which drives data_o and raises done_o for one cycle.
// The accumulator is free again on the cycle after a window closes. Windows
// can therefore run back to back at one sample per clock.
// ---------------------------------------------------------------------------
module mean_filter #(
   parameter int DATA_W = 8,
   parameter int N      = 10,
   parameter int ROUND  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              done_o
);

   // The worst-case sum N*(2^DATA_W-1) always fits in SUM_W bits.
   localparam int SUM_W = DATA_W + $clog2(N);
   localparam int CNT_W = $clog2(N);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
   // The divide path is one bit wider than the sum, so the rounding bias
   // added for ROUND=1 can never wrap.
   localparam logic [SUM_W:0]   DIV  = (SUM_W + 1)'(N);
   localparam logic [SUM_W:0]   HALF = (SUM_W + 1)'(N / 2);

   logic [SUM_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [SUM_W-1:0] total;
   logic             total_valid;

   logic [SUM_W:0]   biased;
   logic [DATA_W-1:0] mean;

   // ------------------------------------------------------------------
   // Accumulation and stage 1
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         cnt         <= '0;
         total       <= '0;
         total_valid <= 1'b0;
      end else begin
         // Stage-1 valid is high only for the cycle after a window closes.
         total_valid <= 1'b0;
         if (en_i) begin
            if (cnt == LAST) begin
               // Window close: the closing sample goes into the total
               // directly, so the accumulator can restart on this edge.
               total       <= acc + SUM_W'(data_i);
               total_valid <= 1'b1;
               acc         <= '0;
               cnt         <= '0;
            end else begin
               acc <= acc + SUM_W'(data_i);
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Constant divide
   // ------------------------------------------------------------------
   always_comb begin
      biased = {1'b0, total};
      if (ROUND != 0) begin
         biased = biased + HALF;
      end
   end

   // The quotient is at most 2^DATA_W-1, including with rounding, because
   // (N*(2^DATA_W-1) + N/2) / N rounds down to 2^DATA_W-1. The narrowing
   // cast therefore drops only zero bits.
   assign mean = DATA_W'(biased / DIV);

   // ------------------------------------------------------------------
   // Stage 2: registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         data_o <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= total_valid;
         if (total_valid) begin
            data_o <= mean;
         end
      end
   end

endmodule

// File: tb/tb_mean_filter.sv
// ---------------------------------------------------------------------------
// tb_mean_filter
//
// Drives identical stimulus into a truncating instance (ROUND=0) and a
// rounding instance (ROUND=1) of mean_filter, both with DATA_W=8 and N=10.
// A reference model in the driver tracks each window. When a window closes,
// the model pushes the expected floor mean, the expected rounded mean and the
// expected output cycle. A negedge monitor pops these when done_o fires. On
// every other cycle it checks that data_o holds its last value.
// ---------------------------------------------------------------------------
module tb_mean_filter;

   localparam int W = 8;
   localparam int N = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en  = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] dout_f, dout_r;
   logic         done_f, done_r;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Scoreboard
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_rq[$];
   int           exp_cyc_q[$];
   logic [W-1:0] last_f = '0;
   logic [W-1:0] last_r = '0;

   // Reference model of the open window
   int m_sum = 0;
   int m_cnt = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mean_filter #(.DATA_W(W), .N(N), .ROUND(0)) dut_f (
      .clk(clk), .rst(rst), .en_i(en), .data_i(din),
      .data_o(dout_f), .done_o(done_f)
   );

   mean_filter #(.DATA_W(W), .N(N), .ROUND(1)) dut_r (
      .clk(clk), .rst(rst), .en_i(en), .data_i(din),
      .data_o(dout_r), .done_o(done_r)
   );

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after the rising edge. After the wait, cyc
   // holds the index of the edge that just sampled the input.
   task automatic send(input logic [W-1:0] d);
      en  = 1'b1;
      din = d;
      @(posedge clk);
      #1;
      m_sum += int'(d);
      m_cnt++;
      if (m_cnt == N) begin
         exp_q.push_back(W'(m_sum / N));
         exp_rq.push_back(W'((m_sum + N / 2) / N));
         exp_cyc_q.push_back(cyc + 1);
         m_sum = 0;
         m_cnt = 0;
      end
      en  = 1'b0;
      din = $urandom_range(0, 255);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         en  = 1'b0;
         din = $urandom_range(0, 255);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      en  = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check_eq("rst_data_f", dout_f, 0);
         check_eq("rst_done_f", done_f, 0);
         check_eq("rst_data_r", dout_r, 0);
         check_eq("rst_done_r", done_r, 0);
      end
      exp_q.delete();
      exp_rq.delete();
      exp_cyc_q.delete();
      m_sum  = 0;
      m_cnt  = 0;
      last_f = '0;
      last_r = '0;
      rst    = 1'b0;
   endtask

   // Feeds the remaining samples back to back, leaving en high between them.
   task automatic send_burst(input int first, input int count);
      for (int i = 0; i < count; i++) begin
         en  = 1'b1;
         din = W'(first + i);
         @(posedge clk);
         #1;
         m_sum += first + i;
         m_cnt++;
         if (m_cnt == N) begin
            exp_q.push_back(W'(m_sum / N));
            exp_rq.push_back(W'((m_sum + N / 2) / N));
            exp_cyc_q.push_back(cyc + 1);
            m_sum = 0;
            m_cnt = 0;
         end
      end
      en = 1'b0;
   endtask

   // Waits a bounded number of cycles for the scoreboard to empty.
   task automatic drain(input string tag);
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) idle(1);
      idle(2);
      check_eq(tag, exp_q.size(), 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst) begin
         check_eq("done_match", done_r, done_f);
         if (done_f) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_done", done_f, 0);
            end else begin
               logic [W-1:0] ef, er;
               int           ec;
               ef = exp_q.pop_front();
               er = exp_rq.pop_front();
               ec = exp_cyc_q.pop_front();
               check_eq("mean_floor", dout_f, ef);
               check_eq("mean_round", dout_r, er);
               check_eq("done_cycle", cyc, ec);
               last_f = ef;
               last_r = er;
            end
         end else begin
            check_eq("hold_floor", dout_f, last_f);
            check_eq("hold_round", dout_r, last_r);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // 1: reset then 1..10, then one idle cycle -> floor 5, round 6
      do_reset(1);
      for (int i = 1; i <= 10; i++) send(W'(i));
      idle(1);
      drain("t1_drain");

      // 2: full scale then zero
      for (int i = 0; i < 10; i++) send(8'd255);
      drain("t2a_drain");
      for (int i = 0; i < 10; i++) send(8'd0);
      drain("t2b_drain");

      // 3: 1..10 with random gaps between samples
      for (int i = 1; i <= 10; i++) begin
         send(W'(i));
         idle($urandom_range(0, 3));
      end
      drain("t3_drain");

      // 4: reset part-way through a window discards the partial sum
      for (int i = 0; i < 6; i++) send(8'd200);
      do_reset(2);
      for (int i = 0; i < 10; i++) send(8'd20);
      drain("t4_drain");

      // 5: back-to-back windows 1..10 and 11..20 with en held high
      send_burst(1, 20);
      drain("t5_drain");

      // 6: sum 54 -> floor 5, round 5 (nine 5s and one 9)
      for (int i = 0; i < 9; i++) send(8'd5);
      send(8'd9);
      drain("t6_drain");

      // sum 55 with en high on the cycle after the close -> floor 5, round 6.
      // The following window (35 x 10 = 350) must not disturb it.
      for (int i = 1; i <= 10; i++) send(W'(i));
      for (int i = 0; i < 10; i++) send(8'd35);
      drain("t6b_drain");

      // random windows with random gaps
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < N; i++) begin
            send(W'($urandom_range(0, 255)));
            idle($urandom_range(0, 2));
         end
      end
      drain("rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global guard against a hung run
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
